// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V decode stage: opcode values, one-hot
// format encoding and the decoded entry record held in the pipeline registers.
package riscv_pkg;

   // Widest supported datapath; decoded_t is sized for it so one record type
   // serves every XLEN (upper bits stay zero when XLEN is 32).
   localparam int XLEN_MAX = 64;
   localparam int FMT_W    = 6;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_IMM_32   = 7'b0011011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_OP_32    = 7'b0111011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   // Bit positions inside the one-hot format vector {R,I,S,B,U,J}
   typedef enum logic [2:0] {
      FMT_J = 3'd0,
      FMT_U = 3'd1,
      FMT_B = 3'd2,
      FMT_S = 3'd3,
      FMT_I = 3'd4,
      FMT_R = 3'd5
   } fmt_e;

   localparam logic [FMT_W-1:0] OH_NONE = 6'b000000;
   localparam logic [FMT_W-1:0] OH_J    = 6'b000001 << FMT_J;
   localparam logic [FMT_W-1:0] OH_U    = 6'b000001 << FMT_U;
   localparam logic [FMT_W-1:0] OH_B    = 6'b000001 << FMT_B;
   localparam logic [FMT_W-1:0] OH_S    = 6'b000001 << FMT_S;
   localparam logic [FMT_W-1:0] OH_I    = 6'b000001 << FMT_I;
   localparam logic [FMT_W-1:0] OH_R    = 6'b000001 << FMT_R;

   // One decoded instruction as it travels from decode into execute
   typedef struct packed {
      logic [XLEN_MAX-1:0] pc;
      logic [FMT_W-1:0]    fmt;
      logic [XLEN_MAX-1:0] imm;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic                illegal;
   } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: assembles the format-specific immediate
// from the instruction word and sign-extends it from bit 31 to XLEN.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      inst,
   input  logic [FMT_W-1:0] fmt,
   output logic [XLEN-1:0]  imm
);

   logic [31:0] imm32_s;

   // Pick the 32-bit immediate layout selected by the one-hot format
   always_comb begin
      imm32_s = 32'd0;
      case (fmt)
         OH_I:    imm32_s = {{20{inst[31]}}, inst[31:20]};
         OH_S:    imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OH_B:    imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OH_U:    imm32_s = {inst[31:12], 12'd0};
         OH_J:    imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         OH_R:    imm32_s = 32'd0;
         default: imm32_s = 32'd0;   // illegal / no format: immediate is zero
      endcase
   end

   // Widen to the datapath; bit 31 always carries the sign
   always_comb begin
      imm = XLEN'($signed(imm32_s));
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RISC-V decode stage. Classifies the incoming instruction by its
// full opcode, builds the immediate, and holds decoded entries in an output
// register backed by one skid register so that a stalled execute stage never
// loses an accepted instruction. Counts accepted illegal instructions.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [FMT_W-1:0] out_fmt,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   logic [6:0]       opcode_s;
   logic [FMT_W-1:0] fmt_s;
   logic             illegal_s;
   logic [XLEN-1:0]  imm_s;
   decoded_t         dec_s;

   decoded_t         out_r;
   decoded_t         skid_r;
   logic             out_valid_r;
   logic             skid_valid_r;
   logic [CNT_W-1:0] count_r;

   logic             accept_s;
   logic             pop_s;

   // Opcode classification; the 64-bit-only word opcodes are illegal on RV32
   always_comb begin
      opcode_s = in_inst[6:0];
      fmt_s    = OH_NONE;
      if (in_inst[1:0] == 2'b11) begin
         case (opcode_s)
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR, OP_SYSTEM: fmt_s = OH_I;
            OP_AUIPC, OP_LUI:                                 fmt_s = OH_U;
            OP_STORE:                                         fmt_s = OH_S;
            OP_OP:                                            fmt_s = OH_R;
            OP_BRANCH:                                        fmt_s = OH_B;
            OP_JAL:                                           fmt_s = OH_J;
            OP_IMM_32: begin
               if (XLEN == 64) begin
                  fmt_s = OH_I;
               end else begin
                  fmt_s = OH_NONE;
               end
            end
            OP_OP_32: begin
               if (XLEN == 64) begin
                  fmt_s = OH_R;
               end else begin
                  fmt_s = OH_NONE;
               end
            end
            default: fmt_s = OH_NONE;
         endcase
      end else begin
         fmt_s = OH_NONE;   // compressed / non-32-bit encodings are not supported
      end
      illegal_s = (fmt_s == OH_NONE);
   end

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .inst (in_inst),
      .fmt  (fmt_s),
      .imm  (imm_s)
   );

   // Assemble the decoded record that will be captured on accept
   always_comb begin
      dec_s         = '0;
      dec_s.pc      = XLEN_MAX'(in_pc);
      dec_s.fmt     = fmt_s;
      dec_s.imm     = XLEN_MAX'(imm_s);
      dec_s.rd      = in_inst[11:7];
      dec_s.rs1     = in_inst[19:15];
      dec_s.rs2     = in_inst[24:20];
      dec_s.funct3  = in_inst[14:12];
      dec_s.funct7  = in_inst[31:25];
      dec_s.illegal = illegal_s;
   end

   // in_ready is a register copy: space exists while the skid slot is empty
   assign accept_s = in_valid & in_ready;
   assign pop_s    = out_valid_r & out_ready;

   // Output register + skid slot: refill from skid first to keep FIFO order
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r        <= '0;
         skid_r       <= '0;
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (!out_valid_r || pop_s) begin
         if (skid_valid_r) begin
            out_r        <= skid_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_r       <= dec_s;
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (accept_s) begin
         // Output is stalled: park the new entry in the skid slot
         skid_r       <= dec_s;
         skid_valid_r <= 1'b1;
      end
   end

   // Saturating count of illegal instructions taken in (flushed input excluded)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
      end else if (!flush && accept_s && illegal_s && (count_r != {CNT_W{1'b1}})) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign in_ready      = ~skid_valid_r;
   assign out_valid     = out_valid_r;
   assign out_pc        = out_r.pc[XLEN-1:0];
   assign out_fmt       = out_r.fmt;
   assign out_imm       = out_r.imm[XLEN-1:0];
   assign out_rd        = out_r.rd;
   assign out_rs1       = out_r.rs1;
   assign out_rs2       = out_r.rs2;
   assign out_funct3    = out_r.funct3;
   assign out_funct7    = out_r.funct7;
   assign out_illegal   = out_r.illegal;
   assign illegal_count = count_r;

   // Record fields are XLEN_MAX wide; when XLEN is narrower the upper bits
   // are constant zero and are folded here so nothing dangles.
   logic unused_hi;
   assign unused_hi = ^{out_r.pc, out_r.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. Three instances share one stimulus
// stream: A (XLEN=32, CNT_W=16), B (XLEN=64, CNT_W=16), C (XLEN=32, CNT_W=2).
// A depth-2 queue model predicts handshake and contents for all of them.
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        ov_a, ir_a, ill_a;
   logic [31:0] pc_a, imm_a;
   logic [5:0]  fmt_a;
   logic [4:0]  rd_a, rs1_a, rs2_a;
   logic [2:0]  f3_a;
   logic [6:0]  f7_a;
   logic [15:0] cnt_a;

   logic        ov_b, ir_b, ill_b;
   logic [63:0] pc_b, imm_b;
   logic [5:0]  fmt_b;
   logic [4:0]  rd_b, rs1_b, rs2_b;
   logic [2:0]  f3_b;
   logic [6:0]  f7_b;
   logic [15:0] cnt_b;

   logic        ov_c, ir_c, ill_c;
   logic [31:0] pc_c, imm_c;
   logic [5:0]  fmt_c;
   logic [4:0]  rd_c, rs1_c, rs2_c;
   logic [2:0]  f3_c;
   logic [6:0]  f7_c;
   logic [1:0]  cnt_c;

   decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov_a), .out_ready(out_ready),
      .out_pc(pc_a), .out_fmt(fmt_a), .out_imm(imm_a), .out_rd(rd_a), .out_rs1(rs1_a),
      .out_rs2(rs2_a), .out_funct3(f3_a), .out_funct7(f7_a), .out_illegal(ill_a),
      .illegal_count(cnt_a));

   decode_stage #(.XLEN(64), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
      .out_pc(pc_b), .out_fmt(fmt_b), .out_imm(imm_b), .out_rd(rd_b), .out_rs1(rs1_b),
      .out_rs2(rs2_b), .out_funct3(f3_b), .out_funct7(f7_b), .out_illegal(ill_b),
      .illegal_count(cnt_b));

   decode_stage #(.XLEN(32), .CNT_W(2)) dut_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov_c), .out_ready(out_ready),
      .out_pc(pc_c), .out_fmt(fmt_c), .out_imm(imm_c), .out_rd(rd_c), .out_rs1(rs1_c),
      .out_rs2(rs2_c), .out_funct3(f3_c), .out_funct7(f7_c), .out_illegal(ill_c),
      .illegal_count(cnt_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int          XL   [3] = '{32, 64, 32};
   localparam int unsigned CMAX [3] = '{65535, 65535, 3};

   // Reference model: accepted-but-not-consumed entries, oldest first
   logic [31:0] q_inst [$];
   logic [63:0] q_pc   [$];
   int unsigned cnt_m  [3];

   typedef struct {
      logic [31:0] inst;
      logic [5:0]  fmt32;
      logic [63:0] imm32;
      logic        ill32;
      logic [5:0]  fmt64;
      logic [63:0] imm64;
      logic        ill64;
      logic [4:0]  rd;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", nm, k, act, exp);
      end
   endtask

   // Decode rules written straight from the ISA format tables
   function automatic void ref_decode(input logic [31:0] i, input int xl,
                                      output logic [5:0] fmt, output logic [63:0] imm,
                                      output logic ill);
      logic [6:0] op;
      op  = i[6:0];
      fmt = 6'b000000;
      imm = 64'd0;
      if (op inside {7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011} ||
          (xl == 64 && op == 7'b0011011))                      fmt = 6'b010000;
      else if (op inside {7'b0010111, 7'b0110111})             fmt = 6'b000010;
      else if (op == 7'b0100011)                               fmt = 6'b001000;
      else if (op == 7'b0110011 || (xl == 64 && op == 7'b0111011)) fmt = 6'b100000;
      else if (op == 7'b1100011)                               fmt = 6'b000100;
      else if (op == 7'b1101111)                               fmt = 6'b000001;
      ill = (fmt == 6'b000000) || (i[1:0] != 2'b11);
      case (fmt)
         6'b010000: imm = {{52{i[31]}}, i[31:20]};
         6'b001000: imm = {{52{i[31]}}, i[31:25], i[11:7]};
         6'b000100: imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         6'b000010: imm = {{32{i[31]}}, i[31:12], 12'd0};
         6'b000001: imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:   imm = 64'd0;
      endcase
      if (xl == 32) imm = imm & 64'h0000_0000_ffff_ffff;
   endfunction

   task automatic check_inst(input int k, input logic ov, input logic ir, input logic [5:0] fmt,
                             input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic ill, input logic [63:0] cnt);
      logic [5:0]  ef;
      logic [63:0] ei;
      logic        eil;
      logic [63:0] mask;
      logic [31:0] w;
      mask = (XL[k] == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
      chk(k, "out_valid", 64'(ov), 64'(q_inst.size() > 0));
      chk(k, "in_ready", 64'(ir), 64'(q_inst.size() < 2));
      chk(k, "illegal_count", cnt, 64'(cnt_m[k]));
      if (q_inst.size() > 0) begin
         w = q_inst[0];
         ref_decode(w, XL[k], ef, ei, eil);
         chk(k, "out_fmt", 64'(fmt), 64'(ef));
         chk(k, "out_imm", imm, ei);
         chk(k, "out_illegal", 64'(ill), 64'(eil));
         chk(k, "out_pc", pc, q_pc[0] & mask);
         chk(k, "out_rd", 64'(rd), 64'(w[11:7]));
         chk(k, "out_rs1", 64'(rs1), 64'(w[19:15]));
         chk(k, "out_rs2", 64'(rs2), 64'(w[24:20]));
         chk(k, "out_funct3", 64'(f3), 64'(w[14:12]));
         chk(k, "out_funct7", 64'(f7), 64'(w[31:25]));
      end
   endtask

   task automatic model_clear();
      q_inst.delete();
      q_pc.delete();
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
   endtask

   // Advance the model by the edge that follows the inputs just driven
   task automatic model_step();
      bit          acc;
      logic [5:0]  f;
      logic [63:0] im;
      logic        il;
      if (flush) begin
         q_inst.delete();
         q_pc.delete();
      end else begin
         acc = in_valid && (q_inst.size() < 2);
         if (q_inst.size() > 0 && out_ready) begin
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
         end
         if (acc) begin
            q_inst.push_back(in_inst);
            q_pc.push_back(in_pc);
            for (int k = 0; k < 3; k++) begin
               ref_decode(in_inst, XL[k], f, im, il);
               if (il && cnt_m[k] < CMAX[k]) cnt_m[k]++;
            end
         end
      end
   endtask

   task automatic wait_neg();
      @(negedge clk);
      check_inst(0, ov_a, ir_a, fmt_a, 64'(imm_a), 64'(pc_a), rd_a, rs1_a, rs2_a, f3_a, f7_a, ill_a, 64'(cnt_a));
      check_inst(1, ov_b, ir_b, fmt_b, imm_b, pc_b, rd_b, rs1_b, rs2_b, f3_b, f7_b, ill_b, 64'(cnt_b));
      check_inst(2, ov_c, ir_c, fmt_c, 64'(imm_c), 64'(pc_c), rd_c, rs1_c, rs2_c, f3_c, f7_c, ill_c, 64'(cnt_c));
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      model_step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  ops [13];
      logic [31:0] r;
      logic [63:0] rp;
      logic [6:0]  op;
      int unsigned idx;
      int unsigned cnt_before;

      ops = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011, 7'b0010111,
              7'b0110111, 7'b0100011, 7'b0110011, 7'b0111011, 7'b1100011, 7'b1101111};

      tbl[0]  = '{32'h0c300093, 6'b010000, 64'h0000_00c3, 1'b0, 6'b010000, 64'h0000_00c3, 1'b0, 5'd1};
      tbl[1]  = '{32'haaaaa0b7, 6'b000010, 64'haaaa_a000, 1'b0, 6'b000010, 64'hffff_ffff_aaaa_a000, 1'b0, 5'd1};
      tbl[2]  = '{32'haa112523, 6'b001000, 64'hffff_faaa, 1'b0, 6'b001000, 64'hffff_ffff_ffff_faaa, 1'b0, 5'd10};
      tbl[3]  = '{32'h0e000a63, 6'b000100, 64'h0000_00f4, 1'b0, 6'b000100, 64'h0000_00f4, 1'b0, 5'd20};
      tbl[4]  = '{32'h0dc0006f, 6'b000001, 64'h0000_00dc, 1'b0, 6'b000001, 64'h0000_00dc, 1'b0, 5'd0};
      tbl[5]  = '{32'h0000001b, 6'b000000, 64'h0,         1'b1, 6'b010000, 64'h0,         1'b0, 5'd0};
      tbl[6]  = '{32'h00000000, 6'b000000, 64'h0,         1'b1, 6'b000000, 64'h0,         1'b1, 5'd0};
      tbl[7]  = '{32'h0000007f, 6'b000000, 64'h0,         1'b1, 6'b000000, 64'h0,         1'b1, 5'd0};
      tbl[8]  = '{32'h002081b3, 6'b100000, 64'h0,         1'b0, 6'b100000, 64'h0,         1'b0, 5'd3};
      tbl[9]  = '{32'h0000003b, 6'b000000, 64'h0,         1'b1, 6'b100000, 64'h0,         1'b0, 5'd0};
      tbl[10] = '{32'hfff00093, 6'b010000, 64'hffff_ffff, 1'b0, 6'b010000, 64'hffff_ffff_ffff_ffff, 1'b0, 5'd1};
      tbl[11] = '{32'h00000091, 6'b000000, 64'h0,         1'b1, 6'b000000, 64'h0,         1'b1, 5'd1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'd0; in_pc = 64'd0;
      model_clear();

      // Reset state
      repeat (2) @(negedge clk);
      chk(0, "rst_out_valid", 64'(ov_a), 64'd0);
      chk(0, "rst_in_ready", 64'(ir_a), 64'd1);
      chk(0, "rst_count", 64'(cnt_a), 64'd0);
      chk(0, "rst_out_pc", 64'(pc_a), 64'd0);
      chk(0, "rst_out_fmt", 64'(fmt_a), 64'd0);
      chk(0, "rst_out_imm", 64'(imm_a), 64'd0);
      chk(0, "rst_out_illegal", 64'(ill_a), 64'd0);
      chk(1, "rst_out_valid", 64'(ov_b), 64'd0);
      chk(1, "rst_out_imm", imm_b, 64'd0);
      chk(2, "rst_in_ready", 64'(ir_c), 64'd1);
      reset = 1'b0;

      // Table-driven decode vectors, one instruction at a time
      for (int i = 0; i < 12; i++) begin
         wait_neg();
         drive(1'b1, tbl[i].inst, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
         wait_neg();
         chk(0, $sformatf("tbl%0d_valid", i), 64'(ov_a), 64'd1);
         chk(0, $sformatf("tbl%0d_fmt", i), 64'(fmt_a), 64'(tbl[i].fmt32));
         chk(0, $sformatf("tbl%0d_imm", i), 64'(imm_a), tbl[i].imm32);
         chk(0, $sformatf("tbl%0d_illegal", i), 64'(ill_a), 64'(tbl[i].ill32));
         chk(0, $sformatf("tbl%0d_rd", i), 64'(rd_a), 64'(tbl[i].rd));
         chk(1, $sformatf("tbl%0d_fmt", i), 64'(fmt_b), 64'(tbl[i].fmt64));
         chk(1, $sformatf("tbl%0d_imm", i), imm_b, tbl[i].imm64);
         chk(1, $sformatf("tbl%0d_illegal", i), 64'(ill_b), 64'(tbl[i].ill64));
         chk(2, $sformatf("tbl%0d_illegal", i), 64'(ill_c), 64'(tbl[i].ill32));
         drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      end
      wait_neg();
      chk(0, "tbl_count", 64'(cnt_a), 64'd5);
      chk(1, "tbl_count", 64'(cnt_b), 64'd3);
      chk(2, "tbl_count_sat", 64'(cnt_c), 64'd3);

      // Backpressure: three offered, two taken, drained in order
      drive(1'b1, 32'h00100093, 64'h100, 1'b0, 1'b0);
      wait_neg();
      drive(1'b1, 32'h00200113, 64'h104, 1'b0, 1'b0);
      wait_neg();
      drive(1'b1, 32'h00300193, 64'h108, 1'b0, 1'b0);
      wait_neg();
      chk(0, "bp_in_ready", 64'(ir_a), 64'd0);
      chk(0, "bp_hold_pc", 64'(pc_a), 64'h100);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      wait_neg();
      chk(0, "bp_second_pc", 64'(pc_a), 64'h104);
      chk(0, "bp_second_valid", 64'(ov_a), 64'd1);
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      wait_neg();
      chk(0, "bp_drained", 64'(ov_a), 64'd0);

      // Flush with both slots occupied and an illegal instruction offered
      drive(1'b1, 32'h00000093, 64'h200, 1'b0, 1'b0);
      wait_neg();
      drive(1'b1, 32'h002081b3, 64'h204, 1'b0, 1'b0);
      wait_neg();
      chk(0, "fl_full", 64'(ir_a), 64'd0);
      cnt_before = cnt_m[0];
      drive(1'b1, 32'h00000000, 64'h208, 1'b0, 1'b1);
      wait_neg();
      chk(0, "fl_out_valid", 64'(ov_a), 64'd0);
      chk(0, "fl_in_ready", 64'(ir_a), 64'd1);
      chk(0, "fl_count", 64'(cnt_a), 64'(cnt_before));
      drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

      // Randomized traffic against the queue model
      for (int n = 0; n < 1500; n++) begin
         wait_neg();
         idx = $urandom_range(0, 13);
         if (idx == 13) op = 7'($urandom_range(0, 127));
         else op = ops[idx];
         r  = $urandom();
         rp = {32'($urandom()), 32'($urandom())};
         drive(($urandom_range(0, 9) < 7), {r[31:7], op}, rp,
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
      end

      // Asynchronous reset between edges with entries in flight
      wait_neg();
      drive(1'b1, 32'h00000000, 64'h300, 1'b0, 1'b0);
      wait_neg();
      drive(1'b1, 32'h00000093, 64'h304, 1'b0, 1'b0);
      wait_neg();
      #2 reset = 1'b1;
      #1;
      chk(0, "arst_out_valid", 64'(ov_a), 64'd0);
      chk(0, "arst_count", 64'(cnt_a), 64'd0);
      chk(0, "arst_in_ready", 64'(ir_a), 64'd1);
      chk(1, "arst_out_valid", 64'(ov_b), 64'd0);
      chk(2, "arst_count", 64'(cnt_c), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      wait_neg();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
